// File: rtl/inst_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_unit
// Purpose  : Instruction fetch stage. Owns the fetch PC, issues word reads to
//            instruction memory over a variable-latency req/ack handshake and
//            queues returned words with their PCs for the decode stage.
// Ports    : Clk, Rst (async, active-high)
//            Redirect/Target  - load new fetch address, flush the queue
//            Consume          - decode pops the head entry
//            Imem_req/addr    - registered read request to memory
//            Imem_ack/rdata   - memory response for the pending request
//            Valid/Inst/InstPC- head of the prefetch queue (0 when empty)
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Redirect,
  input  logic [31:0] Target,
  input  logic        Consume,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  output logic        Valid,
  output logic [31:0] Inst,
  output logic [31:0] InstPC
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // no request outstanding
    REQ  = 2'd1,   // request outstanding, returned word is kept
    DROP = 2'd2    // request outstanding, returned word is discarded
  } state_t;

  state_t             state_q,    state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               req_q,      req_d;
  logic [31:0]        addr_q,     addr_d;
  logic [CNT_W-1:0]   count_q,    count_d;
  logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [31:0]        buf_inst_q [DEPTH];
  logic [31:0]        buf_inst_d [DEPTH];
  logic [31:0]        buf_pc_q   [DEPTH];
  logic [31:0]        buf_pc_d   [DEPTH];

  logic               push;
  logic               pop;
  logic [31:0]        target_aligned;
  logic [31:0]        pc_plus4;

  assign target_aligned = Target & ~32'd3;
  assign pc_plus4       = fetch_pc_q + 32'd4;   // wraps modulo 2^32

  // Redirect flushes the queue, so neither a push nor a pop may land that cycle.
  assign pop  = Consume & Valid & ~Redirect;
  assign push = (state_q == REQ) & Imem_ack & ~Redirect;

  // Queue bookkeeping
  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    if (Redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        buf_inst_d[wr_ptr_q] = Imem_rdata;
        buf_pc_d[wr_ptr_q]   = addr_q;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
    end
  end

  // Fetch FSM. Requests are only issued when the post-update occupancy leaves
  // room, and occupancy cannot grow while a request is pending, so every
  // returned word always has a free slot.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        if (Redirect) begin
          fetch_pc_d = target_aligned;
        end else if (count_d < C_DEPTH) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (Redirect) begin
          fetch_pc_d = target_aligned;
          if (Imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DROP;   // request must stay up until acknowledged
          end
        end else if (Imem_ack) begin
          fetch_pc_d = pc_plus4;
          if (count_d < C_DEPTH) begin
            addr_d = pc_plus4;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (Redirect) begin
          fetch_pc_d = target_aligned;
        end
        if (Imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst_q[i] <= 32'd0;
        buf_pc_q[i]   <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  assign Imem_req  = req_q;
  assign Imem_addr = addr_q;
  assign Valid     = (count_q != '0);
  assign Inst      = Valid ? buf_inst_q[rd_ptr_q] : 32'd0;
  assign InstPC    = Valid ? buf_pc_q[rd_ptr_q]   : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch_unit
// Purpose  : Directed self-checking bench for inst_prefetch_unit with a
//            configurable-latency instruction memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Redirect = 1'b0;
  logic [31:0] Target = 32'd0;
  logic        Consume = 1'b0;
  logic        Imem_ack = 1'b0;
  logic [31:0] Imem_rdata = 32'd0;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Valid;
  logic [31:0] Inst;
  logic [31:0] InstPC;

  int tests_run    = 0;
  int tests_failed = 0;
  int lat          = 1;
  int hold         = 0;
  bit auto_mem     = 1'b0;

  inst_prefetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .Clk(Clk), .Rst(Rst), .Redirect(Redirect), .Target(Target),
    .Consume(Consume), .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
    .Imem_req(Imem_req), .Imem_addr(Imem_addr), .Valid(Valid),
    .Inst(Inst), .InstPC(InstPC)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 1) ^ 32'hC0DE_1357;
  endfunction

  // Memory responder: acknowledges after the request has been up 'lat' cycles.
  task automatic mem_drive();
    if (Imem_req) begin
      hold++;
      if (hold >= lat) begin
        Imem_ack   = 1'b1;
        Imem_rdata = mem_word(Imem_addr);
        hold       = 0;
      end else begin
        Imem_ack   = 1'b0;
        Imem_rdata = 32'd0;
      end
    end else begin
      Imem_ack   = 1'b0;
      Imem_rdata = 32'd0;
      hold       = 0;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (auto_mem) mem_drive();
  endtask

  task automatic do_reset();
    Rst = 1'b1; auto_mem = 1'b0; Imem_ack = 1'b0; Imem_rdata = 32'd0;
    Redirect = 1'b0; Consume = 1'b0; hold = 0;
    @(posedge Clk); @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    tests_run++;
    if (Imem_req !== 1'b0 || Imem_addr !== 32'd0 || Valid !== 1'b0 ||
        Inst !== 32'd0 || InstPC !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset: req=%b addr=%h valid=%b inst=%h pc=%h, expected all 0",
               Imem_req, Imem_addr, Valid, Inst, InstPC);
    end
  endtask

  task automatic test_streaming();
    do_reset(); lat = 1; auto_mem = 1'b1; Consume = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++;
      if (Imem_req !== 1'b1 || Imem_addr !== 32'(4*k)) begin
        tests_failed++;
        $display("FAIL stream_addr[%0d]: req=%b addr=%h, expected req=1 addr=%h",
                 k, Imem_req, Imem_addr, 32'(4*k));
      end
      if (k == 0) begin
        tests_run++;
        if (Valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_startup: valid=%b, expected 0", Valid);
        end
      end else begin
        tests_run++;
        if (Valid !== 1'b1 || InstPC !== 32'(4*(k-1)) || Inst !== mem_word(32'(4*(k-1)))) begin
          tests_failed++;
          $display("FAIL stream_head[%0d]: valid=%b pc=%h inst=%h, expected 1 %h %h",
                   k, Valid, InstPC, Inst, 32'(4*(k-1)), mem_word(32'(4*(k-1))));
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp_pc, prev_addr;
    logic        prev_req, prev_ack;
    int          words;
    do_reset(); lat = 3; auto_mem = 1'b1; Consume = 1'b1;
    exp_pc = 32'd0; words = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'd0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (prev_req && !prev_ack) begin
        tests_run++;
        if (Imem_req !== 1'b1 || Imem_addr !== prev_addr) begin
          tests_failed++;
          $display("FAIL lat_hold[%0d]: req=%b addr=%h, expected 1 %h",
                   c, Imem_req, Imem_addr, prev_addr);
        end
      end
      if (Valid === 1'b1) begin
        tests_run++;
        if (InstPC !== exp_pc || Inst !== mem_word(exp_pc)) begin
          tests_failed++;
          $display("FAIL lat_order[%0d]: pc=%h inst=%h, expected %h %h",
                   c, InstPC, Inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        words++;
      end
      prev_req = Imem_req; prev_addr = Imem_addr; prev_ack = Imem_ack;
    end
    tests_run++;
    if (words != 13) begin
      tests_failed++;
      $display("FAIL lat_count: words=%0d, expected 13", words);
    end
  endtask

  // Back-pressure stall followed by a redirect while the fetch of 8 is pending.
  task automatic test_backpressure_redirect();
    logic [31:0] got_pc [2];
    logic [31:0] got_inst [2];
    int          n;
    do_reset(); lat = 1; auto_mem = 1'b1; Consume = 1'b0;
    tick();
    tick();
    tick();
    tests_run++;
    if (Imem_req !== 1'b0 || Valid !== 1'b1 || InstPC !== 32'd0 || Inst !== mem_word(32'd0)) begin
      tests_failed++;
      $display("FAIL full_stall: req=%b valid=%b pc=%h inst=%h, expected 0 1 0 %h",
               Imem_req, Valid, InstPC, Inst, mem_word(32'd0));
    end
    tick();
    tests_run++;
    if (Imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_hold: req=%b, expected 0", Imem_req);
    end
    lat = 3; Consume = 1'b1;
    tick();
    Consume = 1'b0;
    tests_run++;
    if (Valid !== 1'b1 || InstPC !== 32'd4 || Imem_req !== 1'b1 || Imem_addr !== 32'd8) begin
      tests_failed++;
      $display("FAIL pop_refill: valid=%b pc=%h req=%b addr=%h, expected 1 4 1 8",
               Valid, InstPC, Imem_req, Imem_addr);
    end
    Redirect = 1'b1; Target = 32'h100;
    tick();
    Redirect = 1'b0;
    tests_run++;
    if (Valid !== 1'b0 || Imem_req !== 1'b1 || Imem_addr !== 32'd8) begin
      tests_failed++;
      $display("FAIL redir_flush: valid=%b req=%b addr=%h, expected 0 1 8",
               Valid, Imem_req, Imem_addr);
    end
    tick();
    tests_run++;
    if (Valid !== 1'b0 || Imem_req !== 1'b1 || Imem_addr !== 32'd8) begin
      tests_failed++;
      $display("FAIL drop_hold: valid=%b req=%b addr=%h, expected 0 1 8",
               Valid, Imem_req, Imem_addr);
    end
    tick();
    tests_run++;
    if (Valid !== 1'b0 || Imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_done: valid=%b req=%b, expected 0 0", Valid, Imem_req);
    end
    tick();
    tests_run++;
    if (Imem_req !== 1'b1 || Imem_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL redir_fetch: req=%b addr=%h, expected 1 100", Imem_req, Imem_addr);
    end
    Consume = 1'b1; n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      tick();
      if (Valid === 1'b1) begin
        got_pc[n] = InstPC; got_inst[n] = Inst; n++;
      end
    end
    Consume = 1'b0;
    tests_run++;
    if (n != 2 || got_pc[0] !== 32'h100 || got_inst[0] !== mem_word(32'h100) ||
        got_pc[1] !== 32'h104 || got_inst[1] !== mem_word(32'h104)) begin
      tests_failed++;
      $display("FAIL redir_seq: n=%0d pcs=%h,%h, expected 2 00000100,00000104",
               n, got_pc[0], got_pc[1]);
    end
  endtask

  task automatic test_redirect_on_ack();
    do_reset(); lat = 1; auto_mem = 1'b1; Consume = 1'b1;
    tick();
    Redirect = 1'b1; Target = 32'h203;
    tick();
    Redirect = 1'b0;
    tests_run++;
    if (Valid !== 1'b0 || Imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_redir_drop: valid=%b req=%b, expected 0 0", Valid, Imem_req);
    end
    tick();
    tests_run++;
    if (Imem_req !== 1'b1 || Imem_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL ack_redir_addr: req=%b addr=%h, expected 1 200", Imem_req, Imem_addr);
    end
    tick();
    tests_run++;
    if (Valid !== 1'b1 || InstPC !== 32'h200 || Inst !== mem_word(32'h200)) begin
      tests_failed++;
      $display("FAIL ack_redir_data: valid=%b pc=%h inst=%h, expected 1 200 %h",
               Valid, InstPC, Inst, mem_word(32'h200));
    end
  endtask

  task automatic test_wrap();
    do_reset(); lat = 1; auto_mem = 1'b1; Consume = 1'b1;
    tick();
    Redirect = 1'b1; Target = 32'hFFFF_FFFE;
    tick();
    Redirect = 1'b0;
    tick();
    tests_run++;
    if (Imem_req !== 1'b1 || Imem_addr !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_addr: req=%b addr=%h, expected 1 fffffffc", Imem_req, Imem_addr);
    end
    tick();
    tests_run++;
    if (Valid !== 1'b1 || InstPC !== 32'hFFFF_FFFC || Imem_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL wrap_head: valid=%b pc=%h addr=%h, expected 1 fffffffc 0",
               Valid, InstPC, Imem_addr);
    end
    tick();
    tests_run++;
    if (Valid !== 1'b1 || InstPC !== 32'd0 || Inst !== mem_word(32'd0)) begin
      tests_failed++;
      $display("FAIL wrap_next: valid=%b pc=%h inst=%h, expected 1 0 %h",
               Valid, InstPC, Inst, mem_word(32'd0));
    end
  endtask

  task automatic test_mid_reset();
    do_reset(); lat = 1; auto_mem = 1'b1; Consume = 1'b0;
    tick();
    tick();
    tests_run++;
    if (Valid !== 1'b1 || Imem_req !== 1'b1 || Imem_addr !== 32'd4) begin
      tests_failed++;
      $display("FAIL mrst_pre: valid=%b req=%b addr=%h, expected 1 1 4",
               Valid, Imem_req, Imem_addr);
    end
    Rst = 1'b1;
    #1;
    tests_run++;
    if (Valid !== 1'b0 || Imem_req !== 1'b0 || Imem_addr !== 32'd0 || InstPC !== 32'd0) begin
      tests_failed++;
      $display("FAIL mrst_async: valid=%b req=%b addr=%h pc=%h, expected all 0",
               Valid, Imem_req, Imem_addr, InstPC);
    end
    auto_mem = 1'b0; Imem_ack = 1'b1; Imem_rdata = 32'hBAD0_BAD0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    tests_run++;
    if (Valid !== 1'b0 || Imem_req !== 1'b1 || Imem_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL mrst_stale: valid=%b req=%b addr=%h, expected 0 1 0",
               Valid, Imem_req, Imem_addr);
    end
    auto_mem = 1'b1; hold = 0;
    mem_drive();
    tick();
    tests_run++;
    if (Valid !== 1'b1 || InstPC !== 32'd0 || Inst !== mem_word(32'd0)) begin
      tests_failed++;
      $display("FAIL mrst_restart: valid=%b pc=%h inst=%h, expected 1 0 %h",
               Valid, InstPC, Inst, mem_word(32'd0));
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_latency();
    test_backpressure_redirect();
    test_redirect_on_ack();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
